// File: rtl/oam_dma.sv
// oam_dma: copies DMA_LENGTH bytes from {page, 8'h00} into OAM when the CPU
// writes the DMA start register.
//
// Ports:
//   iClock, iReset           clock, asynchronous active-high reset
//   iCpuWe/iCpuAddr/iCpuData CPU write bus (trigger on DMA_REG_ADDR)
//   oDmaReg                  last value written to the DMA register
//   oDmaActive               high while a transfer is in progress
//   oDmaReadRequest/Addr     source read toward the MMU read path
//   iDmaReadData             source data, one cycle after the address
//   oOamWe/oOamAddr/oOamData OAM write port
module oam_dma #(
    parameter int          DMA_LENGTH   = 160,
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iCpuWe,
    input  logic [15:0] iCpuAddr,
    input  logic [7:0]  iCpuData,
    output logic [7:0]  oDmaReg,
    output logic        oDmaActive,
    output logic        oDmaReadRequest,
    output logic [15:0] oDmaReadAddr,
    input  logic [7:0]  iDmaReadData,
    output logic        oOamWe,
    output logic [7:0]  oOamAddr,
    output logic [7:0]  oOamData
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [7:0] LAST_IDX = 8'(DMA_LENGTH - 1);

    logic [1:0] state;
    logic [7:0] page;
    logic [7:0] idx;        // index of the read issued in the current cycle
    logic [7:0] dma_reg;
    logic       oam_we_q;   // a read was issued last cycle
    logic [7:0] oam_addr_q;
    logic       trigger;
    logic [7:0] src_page;

    assign trigger  = iCpuWe && (iCpuAddr == DMA_REG_ADDR);
    // E0..FF is echo RAM; fold it back onto C0..DF work RAM.
    assign src_page = (iCpuData < 8'hE0) ? iCpuData : (iCpuData - 8'h20);

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state      <= IDLE;
            page       <= 8'h00;
            idx        <= 8'h00;
            dma_reg    <= 8'h00;
            oam_we_q   <= 1'b0;
            oam_addr_q <= 8'h00;
        end else if (trigger) begin
            // Restart from index 0; the read issued this cycle is never written.
            dma_reg  <= iCpuData;
            state    <= RUN;
            page     <= src_page;
            idx      <= 8'h00;
            oam_we_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    oam_we_q   <= 1'b1;
                    oam_addr_q <= idx;
                    if (idx == LAST_IDX) begin
                        state <= DRAIN;     // idx holds so the read address holds
                    end else begin
                        idx <= idx + 8'd1;
                    end
                end
                DRAIN: begin
                    oam_we_q <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    oam_we_q <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign oDmaReg         = dma_reg;
    assign oDmaActive      = (state != IDLE);
    assign oDmaReadRequest = (state == RUN);
    assign oDmaReadAddr    = {page, idx};
    // A trigger cycle never writes OAM, so a retrigger in DRAIN drops the last byte.
    assign oOamWe          = oam_we_q && !trigger;
    assign oOamAddr        = oam_addr_q;
    assign oOamData        = oOamWe ? iDmaReadData : 8'h00;

endmodule

// File: tb/tb_oam_dma.sv
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic [7:0]  dma_reg;
    logic        active;
    logic        rd_req;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data = 8'h00;
    logic        oam_we;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct { int c; logic [15:0] a; logic [7:0] d; } ev_t;
    ev_t wq[$];
    ev_t rq[$];
    int  aq[$];

    oam_dma dut (
        .iClock(clk), .iReset(rst), .iCpuWe(we), .iCpuAddr(addr), .iCpuData(wdata),
        .oDmaReg(dma_reg), .oDmaActive(active), .oDmaReadRequest(rd_req),
        .oDmaReadAddr(rd_addr), .iDmaReadData(rd_data), .oOamWe(oam_we),
        .oOamAddr(oam_addr), .oOamData(oam_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Source RAM: page C1 holds i^5A; other pages add (page-C1) into the xor.
    function automatic logic [7:0] mem(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'hC1);
    endfunction

    always @(posedge clk) rd_data <= mem(rd_addr);

    always @(negedge clk) begin
        #1;
        if (oam_we) wq.push_back('{cyc, {8'h00, oam_addr}, oam_data});
        if (rd_req) rq.push_back('{cyc, rd_addr, 8'h00});
        if (active) aq.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; drives one bus cycle and returns its cycle number.
    task automatic bus(input logic w, input logic [15:0] a, input logic [7:0] d, output int t);
        we = w; addr = a; wdata = d; t = cyc;
        @(negedge clk);
        we = 1'b0; addr = 16'h0000; wdata = 8'h00;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic clear_logs();
        wq.delete(); rq.delete(); aq.delete();
    endtask

    function automatic int write_at(input int c);
        foreach (wq[i]) if (wq[i].c == c) return i;
        return -1;
    endfunction

    initial begin
        int t, t2, k, bad;
        #1;
        chk("rst_dma_reg", dma_reg, 8'h00);
        chk("rst_active", active, 1'b0);
        chk("rst_rd_req", rd_req, 1'b0);
        chk("rst_rd_addr", rd_addr, 16'h0000);
        chk("rst_oam_we", oam_we, 1'b0);
        chk("rst_oam_addr", oam_addr, 8'h00);
        chk("rst_oam_data", oam_data, 8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic transfer from C100.
        clear_logs();
        bus(1'b1, 16'hFF46, 8'hC1, t);
        wait_cyc(t + 170);
        chk("a_wcount", wq.size(), 160);
        chk("a_first_wc", wq[0].c, t + 2);
        chk("a_last_wc", wq[159].c, t + 161);
        bad = 0;
        foreach (wq[i]) if (wq[i].c != t + 2 + i || wq[i].a != 16'(i) ||
                            wq[i].d != (8'(i) ^ 8'h5A)) bad++;
        chk("a_bytes", bad, 0);
        chk("a_act_first", aq[0], t + 1);
        chk("a_act_last", aq[$], t + 161);
        chk("a_act_count", aq.size(), 161);
        chk("a_rd_first", rq[0].a, 16'hC100);
        chk("a_dma_reg", dma_reg, 8'hC1);

        // Echo page folds onto work RAM.
        clear_logs();
        bus(1'b1, 16'hFF46, 8'hF3, t);
        wait_cyc(t + 170);
        chk("b_rcount", rq.size(), 160);
        chk("b_rd_first", rq[0].a, 16'hD300);
        chk("b_rd_last", rq[$].a, 16'hD39F);
        chk("b_dma_reg", dma_reg, 8'hF3);

        // Retrigger mid-run.
        clear_logs();
        bus(1'b1, 16'hFF46, 8'hC0, t);
        wait_cyc(t + 50);
        bus(1'b1, 16'hFF46, 8'hC2, t2);
        wait_cyc(t + 220);
        chk("c_no_wr_t51", write_at(t + 51), 32'hFFFFFFFF);
        k = write_at(t + 52);
        chk("c_wr_t52", k >= 0, 1'b1);
        if (k >= 0) begin
            chk("c_t52_addr", wq[k].a, 16'h0000);
            chk("c_t52_data", wq[k].d, 8'h5B);
        end
        chk("c_act_last", aq[$], t + 211);
        chk("c_last_wc", wq[$].c, t + 211);
        chk("c_last_addr", wq[$].a, 16'h009F);

        // Reset mid-transfer.
        clear_logs();
        bus(1'b1, 16'hFF46, 8'hC1, t);
        wait_cyc(t + 80);
        chk("d_pre_active", active, 1'b1);
        rst = 1'b1;
        #1;
        chk("d_rst_active", active, 1'b0);
        chk("d_rst_oam_we", oam_we, 1'b0);
        chk("d_rst_dma_reg", dma_reg, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
        repeat (200) @(negedge clk);
        chk("d_no_writes", wq.size(), 0);
        chk("d_no_reads", rq.size(), 0);
        chk("d_no_active", aq.size(), 0);

        // Other addresses and reads do nothing.
        bus(1'b1, 16'hFF46, 8'hC1, t);
        wait_cyc(t + 170);
        clear_logs();
        bus(1'b1, 16'hFF47, 8'hC5, t);
        bus(1'b1, 16'hFE00, 8'hC6, t);
        bus(1'b0, 16'hFF46, 8'hC7, t);
        repeat (20) @(negedge clk);
        chk("e_no_writes", wq.size(), 0);
        chk("e_no_active", aq.size(), 0);
        chk("e_dma_reg", dma_reg, 8'hC1);

        // Back-to-back: second trigger lands in the DRAIN cycle.
        clear_logs();
        bus(1'b1, 16'hFF46, 8'hC1, t);
        wait_cyc(t + 161);
        chk("f_drain_active", active, 1'b1);
        bus(1'b1, 16'hFF46, 8'hC3, t2);
        wait_cyc(t + 340);
        chk("f_no_wr_t161", write_at(t + 161), 32'hFFFFFFFF);
        chk("f_no_wr_t162", write_at(t + 162), 32'hFFFFFFFF);
        k = write_at(t + 160);
        chk("f_last_kept", k >= 0 ? wq[k].a : 16'hFFFF, 16'h009E);
        k = write_at(t + 163);
        chk("f_wr_t163", k >= 0, 1'b1);
        if (k >= 0) begin
            chk("f_t163_addr", wq[k].a, 16'h0000);
            chk("f_t163_data", wq[k].d, 8'h58);
        end
        chk("f_wcount", wq.size(), 159 + 160);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
